// File: rtl/multi_interval_timer_if.sv
// multi_interval_timer_if: per-channel control strobes and status of the interval timer bank
interface multi_interval_timer_if #(
    parameter int WIDTH = 10,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] abort;
    logic [CHANNELS-1:0] periodic;
    logic [CHANNELS*WIDTH-1:0] load_value;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;
    logic [CHANNELS*WIDTH-1:0] count;
    logic any_busy;
    modport master (
        output start, abort, periodic, load_value,
        input busy, done, count, any_busy
    );
    modport slave (
        input start, abort, periodic, load_value,
        output busy, done, count, any_busy
    );
endinterface

// File: rtl/multi_interval_timer.sv
// multi_interval_timer: independent prescaled countdown channels with one-shot/periodic expiry pulses
module multi_interval_timer #(
    parameter int WIDTH = 10,
    parameter int CHANNELS = 2,
    parameter int TICK_DIV = 50
) (
    input logic clk,
    input logic reset,
    multi_interval_timer_if.slave bus
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t st;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] rld;
        logic [WIDTH-1:0] n;
        logic [PW-1:0] pre;
        logic mode;
        logic done_q;
        logic tick;
        assign n = bus.load_value[i*WIDTH +: WIDTH];
        assign tick = pre == PW'(TICK_DIV - 1);
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st <= IDLE;
                cnt <= '0;
                rld <= '0;
                pre <= '0;
                mode <= 1'b0;
                done_q <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (bus.abort[i]) begin
                    st <= IDLE;
                    cnt <= '0;
                    pre <= '0;
                end else if (bus.start[i]) begin
                    pre <= '0;
                    // a zero-length interval expires immediately without ever running
                    if (n != '0) begin
                        st <= RUN;
                        cnt <= n;
                        rld <= n;
                        mode <= bus.periodic[i];
                    end else begin
                        st <= IDLE;
                        cnt <= '0;
                        done_q <= 1'b1;
                    end
                end else if (st == RUN) begin
                    if (tick) begin
                        pre <= '0;
                        if (cnt == WIDTH'(1)) begin
                            done_q <= 1'b1;
                            cnt <= mode ? rld : '0;
                            st <= mode ? RUN : IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
            end
        end
        assign bus.busy[i] = st == RUN;
        assign bus.done[i] = done_q;
        assign bus.count[i*WIDTH +: WIDTH] = cnt;
    end
    assign bus.any_busy = |bus.busy;
endmodule

// File: tb/tb_multi_interval_timer.sv
// tb_multi_interval_timer: directed stimulus with a done-pulse scoreboard for TICK_DIV=4 and TICK_DIV=1 instances
module tb_multi_interval_timer;
    logic clk;
    logic reset;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    typedef struct {int at; int mask;} exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e_m0;
    exp_t e_m1;
    int e0;
    int e1;

    multi_interval_timer_if #(.WIDTH(10), .CHANNELS(2)) bus0();
    multi_interval_timer_if #(.WIDTH(4), .CHANNELS(1)) bus1();

    multi_interval_timer #(.WIDTH(10), .CHANNELS(2), .TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    multi_interval_timer #(.WIDTH(4), .CHANNELS(1), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic go(input logic [1:0] m, input int n0, input int n1, input logic [1:0] per, output int e);
        bus0.start = m;
        bus0.load_value = {n1[9:0], n0[9:0]};
        bus0.periodic = per;
        e = cyc + 1;
        @(negedge clk);
        bus0.start = '0;
    endtask

    // scoreboard: each done pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].at < cyc) begin
            e_m0 = q0.pop_front();
            chk("dut0 missed done at cycle", cyc, e_m0.at);
        end
        if (bus0.done != '0) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected done mask", int'(bus0.done), 0);
            end else begin
                e_m0 = q0.pop_front();
                chk("dut0 done cycle", cyc, e_m0.at);
                chk("dut0 done mask", int'(bus0.done), e_m0.mask);
            end
        end
    end

    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].at < cyc) begin
            e_m1 = q1.pop_front();
            chk("dut1 missed done at cycle", cyc, e_m1.at);
        end
        if (bus1.done != '0) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected done", int'(bus1.done), 0);
            end else begin
                e_m1 = q1.pop_front();
                chk("dut1 done cycle", cyc, e_m1.at);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus0.start = '0; bus0.abort = '0; bus0.periodic = '0; bus0.load_value = '0;
        bus1.start = '0; bus1.abort = '0; bus1.periodic = '0; bus1.load_value = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(bus0.busy), 0);
        chk("reset count", int'(bus0.count), 0);
        chk("reset any_busy", int'(bus0.any_busy), 0);
        chk("reset done", int'(bus0.done), 0);
        reset = 1'b1;
        @(negedge clk);

        // one-shot N=3
        go(2'b01, 3, 0, 2'b00, e0);
        q0.push_back('{e0 + 12, 1});
        chk("oneshot busy after start", int'(bus0.busy[0]), 1);
        chk("oneshot count after start", int'(bus0.count[9:0]), 3);
        wait_cyc(e0 + 3); chk("oneshot count e0+3", int'(bus0.count[9:0]), 3);
        wait_cyc(e0 + 4); chk("oneshot count e0+4", int'(bus0.count[9:0]), 2);
        wait_cyc(e0 + 8); chk("oneshot count e0+8", int'(bus0.count[9:0]), 1);
        wait_cyc(e0 + 12);
        chk("oneshot busy after expiry", int'(bus0.busy[0]), 0);
        chk("oneshot count after expiry", int'(bus0.count[9:0]), 0);
        wait_cyc(e0 + 20);

        // periodic N=2 on ch1, then abort
        go(2'b10, 0, 2, 2'b10, e0);
        q0.push_back('{e0 + 8, 2});
        q0.push_back('{e0 + 16, 2});
        q0.push_back('{e0 + 24, 2});
        wait_cyc(e0 + 7); chk("periodic count before reload", int'(bus0.count[19:10]), 1);
        wait_cyc(e0 + 8);
        chk("periodic reload count", int'(bus0.count[19:10]), 2);
        chk("periodic busy held", int'(bus0.busy[1]), 1);
        wait_cyc(e0 + 24); chk("periodic third reload", int'(bus0.count[19:10]), 2);
        wait_cyc(e0 + 26);
        bus0.abort = 2'b10;
        @(negedge clk);
        bus0.abort = '0;
        chk("abort busy", int'(bus0.busy[1]), 0);
        chk("abort count", int'(bus0.count[19:10]), 0);
        wait_cyc(e0 + 50);

        // retrigger N=5 with N=2 after 7 cycles
        go(2'b01, 5, 0, 2'b00, e0);
        wait_cyc(e0 + 6);
        go(2'b01, 2, 0, 2'b00, e1);
        q0.push_back('{e1 + 8, 1});
        chk("retrigger count", int'(bus0.count[9:0]), 2);
        wait_cyc(e1 + 30);

        // zero-length interval
        bus0.start = 2'b01; bus0.load_value = '0; bus0.periodic = 2'b01;
        q0.push_back('{cyc + 1, 1});
        @(negedge clk);
        bus0.start = '0; bus0.periodic = '0;
        chk("zero N busy", int'(bus0.busy[0]), 0);
        @(negedge clk);
        chk("zero N busy later", int'(bus0.busy[0]), 0);
        repeat (3) @(negedge clk);

        // start and abort on the same edge
        bus0.start = 2'b01; bus0.abort = 2'b01; bus0.load_value = 10'd3;
        @(negedge clk);
        bus0.start = '0; bus0.abort = '0;
        chk("start+abort busy", int'(bus0.busy[0]), 0);
        chk("start+abort count", int'(bus0.count[9:0]), 0);
        repeat (20) @(negedge clk);

        // asynchronous reset mid-count
        go(2'b01, 3, 0, 2'b00, e0);
        wait_cyc(e0 + 5);
        #2 reset = 1'b0;
        #1;
        chk("async reset busy", int'(bus0.busy), 0);
        chk("async reset count", int'(bus0.count), 0);
        chk("async reset any_busy", int'(bus0.any_busy), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        go(2'b01, 2, 0, 2'b00, e0);
        q0.push_back('{e0 + 8, 1});
        wait_cyc(e0 + 4); chk("post-reset count", int'(bus0.count[9:0]), 1);
        wait_cyc(e0 + 10);

        // simultaneous expiry on both channels
        go(2'b11, 2, 2, 2'b00, e0);
        q0.push_back('{e0 + 8, 3});
        wait_cyc(e0 + 7); chk("any_busy before expiry", int'(bus0.any_busy), 1);
        wait_cyc(e0 + 8);
        chk("any_busy after expiry", int'(bus0.any_busy), 0);
        chk("both counts after expiry", int'(bus0.count), 0);
        wait_cyc(e0 + 12);

        // TICK_DIV=1 instance: N=1, full-scale N=15, periodic N=1
        bus1.start = 1'b1; bus1.load_value = 4'd1; e0 = cyc + 1;
        @(negedge clk);
        bus1.start = 1'b0;
        q1.push_back('{e0 + 1, 1});
        chk("td1 busy after start", int'(bus1.busy), 1);
        chk("td1 count after start", int'(bus1.count), 1);
        wait_cyc(e0 + 1); chk("td1 busy after expiry", int'(bus1.busy), 0);
        wait_cyc(e0 + 4);
        bus1.start = 1'b1; bus1.load_value = 4'd15; e0 = cyc + 1;
        @(negedge clk);
        bus1.start = 1'b0;
        q1.push_back('{e0 + 15, 1});
        chk("td1 full-scale count", int'(bus1.count), 15);
        wait_cyc(e0 + 14); chk("td1 full-scale count late", int'(bus1.count), 1);
        wait_cyc(e0 + 18);
        bus1.start = 1'b1; bus1.load_value = 4'd1; bus1.periodic = 1'b1; e0 = cyc + 1;
        @(negedge clk);
        bus1.start = 1'b0; bus1.periodic = 1'b0;
        q1.push_back('{e0 + 1, 1});
        q1.push_back('{e0 + 2, 1});
        wait_cyc(e0 + 2);
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        chk("td1 periodic abort busy", int'(bus1.busy), 0);
        repeat (5) @(negedge clk);

        chk("dut0 pending expected dones", q0.size(), 0);
        chk("dut1 pending expected dones", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
